pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. It is the next generation of the lab's 4-bit lookahead carry unit.
- Built from 4-bit groups, each producing group propagate/generate, with a second-level lookahead across the groups.
- Registered in three stages with a valid/ready handshake, so it drops into the datapath as a streaming ALU operand unit.
- Accepts one operation per cycle when not back-pressured.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and in the range 4..64.
- NGROUPS, WIDTH/4, derived localparam: number of 4-bit lookahead groups. Not overridable.

Ports:
- clk  input  1  system clock, all state on the rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry in (ignored when sub=1)
- sub  input  1  0: A+B+c_in; 1: A-B, computed as A+~B+1
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- c_out  output  1  carry out of the MSB (for sub: 1 = no borrow)
- overflow  output  1  signed overflow = carry into MSB XOR c_out
- zero  output  1  sum == 0
- P  output  1  whole-adder propagate (AND of all group P)
- G  output  1  whole-adder generate (second-level lookahead generate)

Behaviour:
- Reset: one clk edge with rst=1 clears all three stage valid bits. sum, c_out, overflow, zero, P and G are all reset to 0.
  - in_ready reads 1 in the cycle after reset deasserts.
  - rst asserted mid-operation flushes every in-flight operation; no partial result is ever presented.
- Handshake:
  - An input is accepted when in_valid & in_ready.
  - An output is consumed when out_valid & out_ready.
  - stall = out_valid & ~out_ready. in_ready = ~stall.
  - While stalled, all stage registers hold and no input is accepted, even if in_valid=1.
  - out_valid, sum and the flags stay stable until consumed.
  - in_valid=0 while not stalled inserts a bubble; the stage valid bits shift as 0.
- Stage 1 (accept edge) registers:
  - b_eff = sub ? ~b : b
  - cin_eff = sub ? 1 : c_in
  - per-bit p = a ^ b_eff and g = a & b_eff
  - per-group Pg = &p[4k+3:4k] and Gg = g3 | p3g2 | p3p2g1 | p3p2p1g0
- Stage 2 registers:
  - Group carries: C0 = cin_eff; C(k+1) = Gg[k] | Pg[k]&C(k), implemented as flattened lookahead, not a ripple chain.
  - Intra-group bit carries from p, g and each group's carry-in.
  - MSB carry-in, c_out, whole-adder P and G.
- Stage 3 registers: sum = p ^ carries, c_out, overflow, zero, P, G.
- Latency: result for an input accepted at edge N has out_valid=1 after edge N+2 (three register stages), assuming no stall.
- Throughput: 1 result/cycle with out_ready held at 1. Back-to-back results must not be dropped or duplicated.
- Arithmetic: modulo 2^WIDTH, no saturation.
- Flags: zero and overflow derive from the registered final sum and carries of the same operation.

Test Plan:
- Reset then idle (WIDTH=16, rst held 2 cycles) -> out_valid=0, sum=0000, in_ready=1 after release.
- Add: a=16'h1234, b=16'h4321, c_in=1, sub=0 -> after 3rd edge, sum=16'h5556, c_out=0, overflow=0, zero=0.
- Full propagate chain: a=16'hFFFF, b=16'h0000, c_in=1 -> sum=16'h0000, c_out=1, zero=1, P=1, G=0. Then a=16'hFFFF, b=16'h0000, c_in=0 -> sum=16'hFFFF, c_out=0, zero=0, P=1, G=0.
- Subtract/overflow:
  - a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, c_out=1, overflow=1.
  - a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, c_out=0, overflow=0.
- Back-pressure: stream 4 operations (i+1)+(i+1) for i=0..3 and drop out_ready for 3 cycles after the first result.
  - in_ready=0 during the stall.
  - Results 2, 4, 6 and 8 emerge in order, each exactly once, and stay stable while stalled.
- Mid-operation reset: accept 2 operations, assert rst on the next edge -> out_valid stays 0 and neither result ever appears. A fresh input afterwards completes with 3-cycle latency.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Purpose: pipelined two-level carry-lookahead adder/subtractor built from 4-bit groups.
// Latency: 3 register stages; an operand accepted on edge N is presented after edge N+2.
// Backpressure: a held output (out_valid & ~out_ready) freezes every stage and drops in_ready.
//
// Ports:
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (a, b, c_in, sub)
//   a, b                  : WIDTH-bit operands
//   c_in                  : carry in, ignored for subtraction
//   sub                   : 0 = a+b+c_in, 1 = a-b (a + ~b + 1)
//   out_valid / out_ready : result handshake
//   sum                   : WIDTH-bit result, modulo 2^WIDTH
//   c_out                 : carry out of the MSB (1 = no borrow when subtracting)
//   overflow              : signed overflow, carry into MSB xor c_out
//   zero                  : sum == 0
//   P, G                  : whole-adder propagate / generate
module pipelined_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             P,
  output logic             G
);

  localparam int NGROUPS = WIDTH / 4;

  // Stage 1: per-bit and per-group propagate/generate plus the effective carry in.
  typedef struct packed {
    logic [WIDTH-1:0]   p;
    logic [WIDTH-1:0]   g;
    logic [NGROUPS-1:0] pg;
    logic [NGROUPS-1:0] gg;
    logic               cin;
  } s1_t;

  // Stage 2: every bit's carry-in is resolved; c[WIDTH-1] is the carry into the MSB.
  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic             c_out;
    logic             grp_p;
    logic             grp_g;
  } s2_t;

  // Stage 3: final registered result and flags.
  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
    logic             zero;
    logic             grp_p;
    logic             grp_g;
  } s3_t;

  s1_t s1_new, s1_d, s1_q;
  s2_t s2_new, s2_d, s2_q;
  s3_t s3_new, s3_d, s3_q;

  logic s1_vld_d, s1_vld_q;
  logic s2_vld_d, s2_vld_q;
  logic s3_vld_d, s3_vld_q;

  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic [NGROUPS:0] grp_c;

  // ------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------
  assign stall    = s3_vld_q & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & ~stall;

  // ------------------------------------------------------------------
  // Stage 1 logic: operand conditioning and group P/G
  // ------------------------------------------------------------------
  always_comb begin : stage1_comb
    b_eff      = sub ? ~b : b;
    s1_new     = '0;
    s1_new.cin = sub ? 1'b1 : c_in;
    s1_new.p   = a ^ b_eff;
    s1_new.g   = a & b_eff;
    for (int k = 0; k < NGROUPS; k++) begin
      s1_new.pg[k] = &s1_new.p[4*k +: 4];
      s1_new.gg[k] = s1_new.g[4*k+3]
                   | (s1_new.p[4*k+3] & s1_new.g[4*k+2])
                   | (s1_new.p[4*k+3] & s1_new.p[4*k+2] & s1_new.g[4*k+1])
                   | (s1_new.p[4*k+3] & s1_new.p[4*k+2] & s1_new.p[4*k+1] & s1_new.g[4*k]);
    end
  end

  // ------------------------------------------------------------------
  // Stage 2 logic: second-level lookahead and intra-group carries
  // ------------------------------------------------------------------
  always_comb begin : stage2_comb
    logic acc;
    logic prod;
    s2_new   = '0;
    grp_c    = '0;
    acc      = 1'b0;
    prod     = 1'b1;
    grp_c[0] = s1_q.cin;
    // Each group carry is an independent sum of products over the lower
    // groups' Gg/Pg and the carry in; the inner loop only enumerates the
    // product terms, it does not chain one group carry into the next.
    for (int k = 0; k < NGROUPS; k++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int j = k; j >= 0; j--) begin
        acc  = acc | (prod & s1_q.gg[j]);
        prod = prod & s1_q.pg[j];
      end
      grp_c[k+1] = acc | (prod & s1_q.cin);
    end
    // After the last iteration acc is the top group's lookahead without
    // the carry-in term: the whole-adder generate.
    s2_new.grp_g = acc;
    s2_new.grp_p = &s1_q.pg;
    s2_new.c_out = grp_c[NGROUPS];
    s2_new.p     = s1_q.p;

    for (int k = 0; k < NGROUPS; k++) begin
      s2_new.c[4*k]   = grp_c[k];
      s2_new.c[4*k+1] = s1_q.g[4*k]
                      | (s1_q.p[4*k] & grp_c[k]);
      s2_new.c[4*k+2] = s1_q.g[4*k+1]
                      | (s1_q.p[4*k+1] & s1_q.g[4*k])
                      | (s1_q.p[4*k+1] & s1_q.p[4*k] & grp_c[k]);
      s2_new.c[4*k+3] = s1_q.g[4*k+2]
                      | (s1_q.p[4*k+2] & s1_q.g[4*k+1])
                      | (s1_q.p[4*k+2] & s1_q.p[4*k+1] & s1_q.g[4*k])
                      | (s1_q.p[4*k+2] & s1_q.p[4*k+1] & s1_q.p[4*k] & grp_c[k]);
    end
  end

  // ------------------------------------------------------------------
  // Stage 3 logic: sum and flags, all from the same operation's stage-2 state
  // ------------------------------------------------------------------
  always_comb begin : stage3_comb
    s3_new          = '0;
    s3_new.sum      = s2_q.p ^ s2_q.c;
    s3_new.c_out    = s2_q.c_out;
    s3_new.overflow = s2_q.c[WIDTH-1] ^ s2_q.c_out;
    s3_new.zero     = ~|(s2_q.p ^ s2_q.c);
    s3_new.grp_p    = s2_q.grp_p;
    s3_new.grp_g    = s2_q.grp_g;
  end

  // ------------------------------------------------------------------
  // Next-state: valid bits shift unless stalled; data registers load only
  // when a real operation moves in, so the output holds its last result
  // through bubbles and stalls.
  // ------------------------------------------------------------------
  always_comb begin : next_state_comb
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;
    s3_vld_d = s3_vld_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    s3_d     = s3_q;
    if (!stall) begin
      s1_vld_d = accept;
      s2_vld_d = s1_vld_q;
      s3_vld_d = s2_vld_q;
      if (accept) begin
        s1_d = s1_new;
      end
      if (s1_vld_q) begin
        s2_d = s2_new;
      end
      if (s2_vld_q) begin
        s3_d = s3_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s3_vld_q <= s3_vld_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign out_valid = s3_vld_q;
  assign sum       = s3_q.sum;
  assign c_out     = s3_q.c_out;
  assign overflow  = s3_q.overflow;
  assign zero      = s3_q.zero;
  assign P         = s3_q.grp_p;
  assign G         = s3_q.grp_g;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Purpose: self-checking bench for pipelined_cla_adder (WIDTH=16), scoreboard driven.
// Latency: expects results 3 edges after acceptance (out_valid after edge N+2).
// Backpressure: exercises stalls via out_ready and checks in_ready/output stability.
module tb_pipelined_cla_adder;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c_out;
    logic         ov;
    logic         zero;
    logic         p;
    logic         g;
  } res_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;
  logic         zero;
  logic         P;
  logic         G;

  int   total;
  int   passed;
  res_t sb[$];

  pipelined_cla_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow),
    .zero     (zero),
    .P        (P),
    .G        (G)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference: plain integer addition on widened operands.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub);
    res_t         r;
    logic [W-1:0] be;
    logic         ci;
    logic [W:0]   full;
    logic [W-1:0] low;
    logic [W:0]   gen;
    be     = msub ? ~mb : mb;
    ci     = msub ? 1'b1 : mcin;
    full   = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, ci};
    low    = {1'b0, ma[W-2:0]} + {1'b0, be[W-2:0]} + {{(W-1){1'b0}}, ci};
    gen    = {1'b0, ma} + {1'b0, be};
    r.sum   = full[W-1:0];
    r.c_out = full[W];
    r.ov    = low[W-1] ^ full[W];
    r.zero  = (full[W-1:0] == '0);
    r.p     = &(ma ^ be);
    r.g     = gen[W];
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r.sum   = sum;
    r.c_out = c_out;
    r.ov    = overflow;
    r.zero  = zero;
    r.p     = P;
    r.g     = G;
    return r;
  endfunction

  // Drives one operation, pushes its expected result, waits (bounded) for out_valid.
  task automatic issue_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic icin, input logic isub,
                          output res_t obs, output int lat, output bit ok);
    @(negedge clk);
    out_ready = 1'b1;
    a = ia; b = ib; c_in = icin; sub = isub; in_valid = 1'b1;
    sb.push_back(model(ia, ib, icin, isub));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    ok  = 1'b0;
    obs = '0;
    while (lat <= 10 && !ok) begin
      if (out_valid) begin
        ok  = 1'b1;
        obs = observed();
      end else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  function automatic res_t pop_exp();
    res_t e;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid);
    else passed++;
    total++;
    if (sum !== 16'h0000) $display("FAIL reset_sum got=%h want=0000", sum);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready);
    else passed++;
    total++;
    if ({out_valid, c_out, overflow, zero, P, G} !== 6'b0)
      $display("FAIL reset_flags got=%b want=000000", {out_valid, c_out, overflow, zero, P, G});
    else passed++;
  endtask

  task automatic test_add();
    res_t obs, exp;
    int   lat;
    bit   ok;
    issue_op(16'h1234, 16'h4321, 1'b1, 1'b0, obs, lat, ok);
    exp = pop_exp();
    total++;
    if (!ok || lat != 3) $display("FAIL add_latency got=%0d ok=%b want=3", lat, ok);
    else passed++;
    total++;
    if (obs !== exp) $display("FAIL add_model got=%h want=%h", obs, exp);
    else passed++;
    total++;
    if ({obs.sum, obs.c_out, obs.ov, obs.zero} !== {16'h5556, 3'b000})
      $display("FAIL add_literal got=%h/%b%b%b want=5556/000", obs.sum, obs.c_out, obs.ov, obs.zero);
    else passed++;
  endtask

  task automatic test_propagate();
    res_t obs, exp;
    int   lat;
    bit   ok;
    issue_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, obs, lat, ok);
    exp = pop_exp();
    total++;
    if (!ok || lat != 3) $display("FAIL prop1_latency got=%0d ok=%b want=3", lat, ok);
    else passed++;
    total++;
    if (obs !== exp) $display("FAIL prop1_model got=%h want=%h", obs, exp);
    else passed++;
    total++;
    if ({obs.sum, obs.c_out, obs.zero, obs.p, obs.g} !== {16'h0000, 4'b1110})
      $display("FAIL prop1_literal got=%h/%b%b%b%b want=0000/1110",
               obs.sum, obs.c_out, obs.zero, obs.p, obs.g);
    else passed++;

    issue_op(16'hFFFF, 16'h0000, 1'b0, 1'b0, obs, lat, ok);
    exp = pop_exp();
    total++;
    if (!ok || lat != 3) $display("FAIL prop0_latency got=%0d ok=%b want=3", lat, ok);
    else passed++;
    total++;
    if (obs !== exp) $display("FAIL prop0_model got=%h want=%h", obs, exp);
    else passed++;
    total++;
    if ({obs.sum, obs.c_out, obs.zero, obs.p, obs.g} !== {16'hFFFF, 4'b0010})
      $display("FAIL prop0_literal got=%h/%b%b%b%b want=FFFF/0010",
               obs.sum, obs.c_out, obs.zero, obs.p, obs.g);
    else passed++;
  endtask

  task automatic test_sub();
    res_t obs, exp;
    int   lat;
    bit   ok;
    issue_op(16'h8000, 16'h0001, 1'b0, 1'b1, obs, lat, ok);
    exp = pop_exp();
    total++;
    if (!ok || obs !== exp) $display("FAIL sub_ovf_model got=%h ok=%b want=%h", obs, ok, exp);
    else passed++;
    total++;
    if ({obs.sum, obs.c_out, obs.ov} !== {16'h7FFF, 2'b11})
      $display("FAIL sub_ovf_literal got=%h/%b%b want=7FFF/11", obs.sum, obs.c_out, obs.ov);
    else passed++;

    // c_in=1 must be ignored while subtracting.
    issue_op(16'h0005, 16'h0007, 1'b1, 1'b1, obs, lat, ok);
    exp = pop_exp();
    total++;
    if (!ok || obs !== exp) $display("FAIL sub_neg_model got=%h ok=%b want=%h", obs, ok, exp);
    else passed++;
    total++;
    if ({obs.sum, obs.c_out, obs.ov} !== {16'hFFFE, 2'b00})
      $display("FAIL sub_neg_literal got=%h/%b%b want=FFFE/00", obs.sum, obs.c_out, obs.ov);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   got = 0;
    int   stall_left = 0;
    int   stall_seen = 0;
    int   cyc = 0;
    bit   first_done = 1'b0;
    bit   have_hold = 1'b0;
    bit   extra = 1'b0;
    res_t hold, obs, exp;
    hold = '0;
    while (got < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      obs = observed();
      if (out_valid && !out_ready) begin
        stall_seen++;
        total++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b want=0", in_ready);
        else passed++;
        if (have_hold) begin
          total++;
          if (obs !== hold) $display("FAIL bp_stable got=%h want=%h", obs, hold);
          else passed++;
        end
        hold      = obs;
        have_hold = 1'b1;
      end
      if (out_valid && out_ready) begin
        exp = pop_exp();
        total++;
        if (obs !== exp) $display("FAIL bp_order got=%h want=%h", obs, exp);
        else passed++;
        total++;
        if (obs.sum !== W'(2 * (got + 1)))
          $display("FAIL bp_value got=%0d want=%0d", obs.sum, 2 * (got + 1));
        else passed++;
        got++;
        have_hold = 1'b0;
        if (!first_done) begin
          first_done = 1'b1;
          stall_left = 3;
        end
      end
      if (sent < 4 && in_ready) begin
        a = W'(sent + 1); b = W'(sent + 1); c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        sb.push_back(model(W'(sent + 1), W'(sent + 1), 1'b0, 1'b0));
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (got != 4) $display("FAIL bp_count got=%0d want=4", got);
    else passed++;
    total++;
    if (stall_seen != 3) $display("FAIL bp_stall_cycles got=%0d want=3", stall_seen);
    else passed++;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra = 1'b1;
    end
    total++;
    if (extra || sb.size() != 0)
      $display("FAIL bp_no_dup got_extra=%b queued=%0d want=0/0", extra, sb.size());
    else passed++;
  endtask

  task automatic test_mid_reset();
    res_t obs, exp;
    int   lat;
    bit   ok;
    bit   leaked = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h3333; b = 16'h4444;
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || sum !== 16'h0000)
      $display("FAIL mrst_flush got=%b/%h want=0/0000", out_valid, sum);
    else passed++;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) leaked = 1'b1;
    end
    total++;
    if (leaked) $display("FAIL mrst_leak got=1 want=0");
    else passed++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL mrst_in_ready got=%b want=1", in_ready);
    else passed++;
    issue_op(16'h00FF, 16'h0101, 1'b0, 1'b0, obs, lat, ok);
    exp = pop_exp();
    total++;
    if (!ok || lat != 3) $display("FAIL mrst_latency got=%0d ok=%b want=3", lat, ok);
    else passed++;
    total++;
    if (obs.sum !== 16'h0200 || obs !== exp)
      $display("FAIL mrst_result got=%h want=%h", obs, exp);
    else passed++;
  endtask

  task automatic test_random_stream();
    int           sent = 0;
    int           got = 0;
    int           cyc = 0;
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    res_t         obs, exp;
    while (got < 16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        obs = observed();
        exp = pop_exp();
        total++;
        if (obs !== exp) $display("FAIL rand_result idx=%0d got=%h want=%h", got, obs, exp);
        else passed++;
        got++;
      end
      if (sent < 16 && in_ready) begin
        ra = W'($urandom); rb = W'($urandom);
        rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
        a = ra; b = rb; c_in = rc; sub = rs; in_valid = 1'b1;
        sb.push_back(model(ra, rb, rc, rs));
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (got != 16 || sb.size() != 0)
      $display("FAIL rand_count got=%0d queued=%0d want=16/0", got, sb.size());
    else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_add();
    test_propagate();
    test_sub();
    test_back_to_back();
    test_mid_reset();
    test_random_stream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
